// File: rtl/motor_ramp_sequencer.sv
// One motor channel: valid/ready speed commands become a slew-limited PWM duty
// and an H-bridge direction pair; a reversal always passes through zero duty plus a dead time.
module motor_ramp_sequencer #(
  parameter int PERIOD       = 2000000,
  parameter int STEP         = 100000,
  parameter int DEAD_PERIODS = 5,
  parameter int W            = 21
) (
  input  logic         clk,
  input  logic         res,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [W-1:0] cmd_duty,
  input  logic         estop,
  output logic         pwm,
  output logic [1:0]   dir,
  output logic [W-1:0] duty_now,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, RAMP, STEADY, STOPPING, DEAD, ESTOP} state_t;

  localparam logic [W-1:0] PERIOD_W = W'(PERIOD);
  localparam logic [W-1:0] LAST_W   = W'(PERIOD - 1);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam int           DW       = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_PERIODS - 1);

  state_t        r_state;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  r_duty;
  logic [W-1:0]  r_target;
  logic [W-1:0]  r_pend_target;
  logic          r_pend_dir;
  logic          r_dir_cur;
  logic          r_pwm;
  logic [DW-1:0] r_dead_cnt;

  logic          w_accept;
  logic          w_frame_end;
  logic [W-1:0]  w_clamp;
  logic [W-1:0]  w_step;
  state_t        w_state;
  logic [W-1:0]  w_target;
  logic [W-1:0]  w_pend_target;
  logic          w_pend_dir;

  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      return cur + ((diff > STEP_W) ? STEP_W : diff);
    end
    diff = cur - tgt;
    return cur - ((diff > STEP_W) ? STEP_W : diff);
  endfunction

  // Where a channel rests once duty and target are known: still moving, parked, or holding.
  function automatic state_t settle(input logic [W-1:0] tgt, input logic [W-1:0] duty);
    if (tgt != duty)  return RAMP;
    if (tgt == '0)    return IDLE;
    return STEADY;
  endfunction

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_frame_end = (r_cnt == LAST_W);
  assign w_clamp     = (cmd_duty > PERIOD_W) ? PERIOD_W : cmd_duty;

  // Command stage: resolves what a newly accepted command does before the frame-end
  // update, so a command landing on frame_end steps toward the new target.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state       = r_state;
    w_target      = r_target;
    w_pend_dir    = r_pend_dir;
    w_pend_target = r_pend_target;
    if (w_accept) begin
      case (r_state)
        IDLE, RAMP, STEADY, STOPPING: begin
          if (cmd_dir == r_dir_cur) begin
            w_target = w_clamp;
            w_state  = settle(w_clamp, r_duty);
          end else begin
            w_pend_dir    = cmd_dir;
            w_pend_target = w_clamp;
            w_target      = '0;
            w_state       = (r_duty != '0) ? STOPPING : DEAD;
          end
        end
        DEAD: begin
          w_pend_dir    = cmd_dir;
          w_pend_target = w_clamp;
        end
        default: ;
      endcase
    end
  end

  assign w_step = step_toward(r_duty, w_target);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (res) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_duty        <= '0;
      r_target      <= '0;
      r_pend_target <= '0;
      r_pend_dir    <= 1'b0;
      r_dir_cur     <= 1'b0;
      r_pwm         <= 1'b0;
      r_dead_cnt    <= '0;
    end else begin
      r_cnt <= w_frame_end ? '0 : r_cnt + W'(1);
      r_pwm <= ~estop & (r_cnt < r_duty);
      if (estop) begin
        r_state       <= ESTOP;
        r_duty        <= '0;
        r_target      <= '0;
        r_pend_target <= '0;
        r_pend_dir    <= r_dir_cur;
        r_dead_cnt    <= '0;
      end else if (r_state == ESTOP) begin
        r_state  <= IDLE;
        r_target <= '0;
      end else begin
        r_state       <= w_state;
        r_target      <= w_target;
        r_pend_dir    <= w_pend_dir;
        r_pend_target <= w_pend_target;
        if (r_state != DEAD) r_dead_cnt <= '0;
        if (w_frame_end) begin
          case (w_state)
            RAMP: begin
              r_duty  <= w_step;
              r_state <= settle(w_target, w_step);
            end
            STOPPING: begin
              r_duty <= w_step;
              if (w_step == '0) r_state <= DEAD;
            end
            DEAD: begin
              // The frame_end that brings us into DEAD does not count as dead time.
              if (r_state == DEAD) begin
                if (r_dead_cnt == DEAD_LAST) begin
                  r_dir_cur <= w_pend_dir;
                  r_target  <= w_pend_target;
                  r_state   <= settle(w_pend_target, '0);
                end else begin
                  r_dead_cnt <= r_dead_cnt + DW'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign cmd_ready = (r_state != ESTOP);
  assign busy      = (r_state == RAMP) || (r_state == STOPPING) ||
                     (r_state == DEAD) || (r_state == ESTOP);
  assign dir       = {~r_dir_cur, r_dir_cur};
  assign duty_now  = r_duty;
  assign pwm       = r_pwm;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios plus random commands/estop/reset,
// every cycle compared against a frame-level behavioural model of the channel.
module tb_motor_ramp_sequencer;

  localparam int PERIOD = 100;
  localparam int STEP   = 25;
  localparam int DEADP  = 2;
  localparam int W      = 8;

  logic         clk = 1'b0;
  logic         res, cmd_valid, cmd_ready, cmd_dir, estop, pwm, busy;
  logic [W-1:0] cmd_duty, duty_now;
  logic [1:0]   dir;

  always #5 clk = ~clk;

  motor_ramp_sequencer #(.PERIOD(PERIOD), .STEP(STEP), .DEAD_PERIODS(DEADP), .W(W)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_duty(cmd_duty), .estop(estop), .pwm(pwm), .dir(dir), .duty_now(duty_now), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: duty, target, direction, a pending reversal and remaining dead frames.
  int m_cnt, m_duty, m_target, m_dir, m_pdir, m_ptarget, m_dead, m_pwm;
  bit m_rev, m_estop_st;

  int seen[$];
  int last_duty;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    int d;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    if (d > STEP) d = STEP;
    return (tgt > cur) ? cur + d : cur - d;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit v, input bit d, input int du);
    int  cl;
    bit  fe, was_dead;
    if (r) begin
      m_cnt = 0; m_duty = 0; m_target = 0; m_dir = 0; m_pdir = 0; m_ptarget = 0;
      m_dead = 0; m_pwm = 0; m_rev = 0; m_estop_st = 0;
      return;
    end
    m_pwm = (!e && (m_cnt < m_duty)) ? 1 : 0;
    fe    = (m_cnt == PERIOD - 1);
    m_cnt = (m_cnt + 1) % PERIOD;
    if (e) begin
      m_duty = 0; m_target = 0; m_rev = 0; m_dead = 0; m_estop_st = 1;
      return;
    end
    if (m_estop_st) begin
      m_estop_st = 0; m_target = 0;
      return;
    end
    cl       = (du > PERIOD) ? PERIOD : du;
    was_dead = (m_dead > 0);
    if (v) begin
      if (was_dead) begin
        m_pdir = d; m_ptarget = cl;
      end else if (d == m_dir) begin
        m_rev = 0; m_target = cl;
      end else begin
        m_rev = 1; m_pdir = d; m_ptarget = cl;
        if (m_duty == 0) m_dead = DEADP;
      end
    end
    if (fe) begin
      if (was_dead) begin
        m_dead--;
        if (m_dead == 0) begin
          m_dir = m_pdir; m_target = m_ptarget; m_rev = 0;
        end
      end else if (m_dead == 0) begin
        if (m_rev) begin
          m_duty = toward(m_duty, 0);
          if (m_duty == 0) m_dead = DEADP;
        end else begin
          m_duty = toward(m_duty, m_target);
        end
      end
    end
  endtask

  task automatic compare_all();
    int busy_exp;
    busy_exp = (m_estop_st || m_rev || m_dead > 0 || m_duty != m_target) ? 1 : 0;
    check("duty_now", duty_now, m_duty);
    check("pwm", pwm, m_pwm);
    check("dir", dir, m_dir ? 1 : 2);
    check("busy", busy, busy_exp);
    check("cmd_ready", cmd_ready, m_estop_st ? 0 : 1);
    if (int'(duty_now) != last_duty) begin
      seen.push_back(int'(duty_now));
      last_duty = int'(duty_now);
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit v, input bit d, input int du);
    res       = r;
    estop     = e;
    cmd_valid = v;
    cmd_dir   = d;
    cmd_duty  = du[W-1:0];
    model_step(r, e, v, d, du);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input bit d, input int du);
    cycle(0, 0, 1, d, du);
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      cycle(0, 0, 0, 0, 0);
      hi += int'(pwm);
    end
  endtask

  task automatic idle_until_duty(input int target, input string tag);
    int n;
    n = 0;
    while (int'(duty_now) != target && n < 400) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    check(tag, int'(duty_now), target);
  endtask

  task automatic check_seen(input string tag, input int exp[]);
    check({tag, "_len"}, seen.size(), exp.size());
    foreach (exp[i]) check(tag, (i < seen.size()) ? seen[i] : -1, exp[i]);
    seen.delete();
  endtask

  initial begin
    int hi, n, es_left;
    bit r, e, v;
    res = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_duty = '0;
    last_duty = -1;
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_duty", int'(duty_now), 0);
    check("rst_dir", int'(dir), 2);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    idle(3);
    seen.delete();

    // Ramp up in steps of 25 to 60, then 60% duty.
    cmd(0, 60);
    idle(320);
    check_seen("t1_ramp", '{25, 50, 60});
    check("t1_busy", int'(busy), 0);
    count_pwm(PERIOD, hi);
    check("t1_pwm_hi", hi, 60);

    // Reversal: ramp down, two dead frames, flip, ramp up.
    cmd(1, 50);
    idle(760);
    check_seen("t2_rev", '{35, 10, 0, 25, 50});
    check("t2_dir", int'(dir), 1);

    // Reversal aborted mid-ramp-down by a same-direction command.
    cmd(0, 50);
    idle_until_duty(25, "t3_reach25");
    seen.delete();
    cmd(1, 80);
    idle(350);
    check_seen("t3_abort", '{50, 75, 80});
    check("t3_dir", int'(dir), 1);

    // Clamp to PERIOD, then ramp to zero.
    cmd(1, 200);
    idle(250);
    check_seen("t4_clamp", '{100});
    count_pwm(PERIOD, hi);
    check("t4_pwm_full", hi, PERIOD);
    cmd(1, 0);
    idle(450);
    check_seen("t4_down", '{75, 50, 25, 0});
    count_pwm(PERIOD, hi);
    check("t4_pwm_zero", hi, 0);
    check("t4_busy", int'(busy), 0);

    // Emergency stop mid-ramp.
    cmd(1, 60);
    idle_until_duty(50, "t5_reach50");
    repeat (30) cycle(0, 1, 1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 100)));
    check("t5_ready", int'(cmd_ready), 0);
    check("t5_duty", int'(duty_now), 0);
    check("t5_pwm", int'(pwm), 0);
    check("t5_dir", int'(dir), 1);
    cycle(0, 0, 1, 0, 70);
    idle(2);
    check("t5_ready_back", int'(cmd_ready), 1);
    check("t5_idle", int'(busy), 0);
    cmd(1, 30);
    idle(220);
    check("t5_new_cmd", int'(duty_now), 30);

    // Reset while in dead time.
    cmd(0, 40);
    n = 0;
    while (m_dead == 0 && n < 400) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    check("t6_in_dead", (m_dead > 0) ? 1 : 0, 1);
    idle(20);
    cycle(1, 0, 0, 0, 0);
    check("t6_duty", int'(duty_now), 0);
    check("t6_dir", int'(dir), 2);
    check("t6_pwm", int'(pwm), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(cmd_ready), 1);
    idle(5);

    // Random commands, estop episodes and resets against the model.
    es_left = 0;
    for (int i = 0; i < 9000; i++) begin
      r = ($urandom % 3000) == 0;
      if (es_left > 0) begin
        e = 1'b1;
        es_left--;
      end else begin
        e = 1'b0;
        if (($urandom % 1500) == 0) es_left = int'($urandom_range(5, 40));
      end
      v = (($urandom % 60) == 0) || (m_cnt == PERIOD - 1 && ($urandom % 4) == 0);
      cycle(r, e, v, 1'($urandom % 2), int'($urandom_range(0, 130)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
